// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: ID-side instruction, hazard-unit controls,
// forwarding data, the registered EX-side fields and the event counters.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_alu_src;
  logic [3:0]       id_alu_op;

  logic             stall;
  logic             flush;
  logic [1:0]       forward_a_src;
  logic [1:0]       forward_b_src;
  logic [XLEN-1:0]  ex_fwd_data;
  logic [XLEN-1:0]  mem_fwd_data;
  logic             ex_ready;
  logic             id_ready;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_op_a;
  logic [XLEN-1:0]  ex_op_b;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_alu_src;
  logic [3:0]       ex_alu_op;
  logic [CNT_W-1:0] bubble_count;
  logic [CNT_W-1:0] flush_count;

  // Driver side: decode stage, hazard unit and downstream stages.
  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_op,
           stall, flush, forward_a_src, forward_b_src, ex_fwd_data, mem_fwd_data,
           ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op,
           bubble_count, flush_count
  );

  // The pipeline register itself.
  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_op,
           stall, flush, forward_a_src, forward_b_src, ex_fwd_data, mem_fwd_data,
           ex_ready,
    output id_ready, ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op,
           bubble_count, flush_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding mux, flush/hold/bubble/load
// sequencing and saturating bubble/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic [XLEN-1:0]  op_a_sel;
  logic [XLEN-1:0]  op_b_sel;

  logic             valid_d,     valid_q;
  logic [XLEN-1:0]  pc_d,        pc_q;
  logic [XLEN-1:0]  op_a_d,      op_a_q;
  logic [XLEN-1:0]  op_b_d,      op_b_q;
  logic [XLEN-1:0]  imm_d,       imm_q;
  logic [4:0]       rs1_d,       rs1_q;
  logic [4:0]       rs2_d,       rs2_q;
  logic [4:0]       rd_d,        rd_q;
  logic             reg_write_d, reg_write_q;
  logic             mem_read_d,  mem_read_q;
  logic             mem_write_d, mem_write_q;
  logic             alu_src_d,   alu_src_q;
  logic [3:0]       alu_op_d,    alu_op_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d,  flush_cnt_q;

  always_comb begin
    unique case (bus.forward_a_src)
      2'b01:   op_a_sel = bus.ex_fwd_data;
      2'b10:   op_a_sel = bus.mem_fwd_data;
      default: op_a_sel = bus.id_rs1_data;
    endcase
    unique case (bus.forward_b_src)
      2'b01:   op_b_sel = bus.ex_fwd_data;
      2'b10:   op_b_sel = bus.mem_fwd_data;
      default: op_b_sel = bus.id_rs2_data;
    endcase
  end

  assign bus.id_ready = bus.ex_ready & ~bus.stall & ~bus.flush;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    alu_src_d    = alu_src_q;
    alu_op_d     = alu_op_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    // Flush and stall both leave a bubble; only the counter differs.
    if (bus.flush || (bus.ex_ready && bus.stall)) begin
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      alu_src_d   = 1'b0;
      alu_op_d    = '0;
      if (bus.flush) begin
        if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
      end else begin
        if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (bus.ex_ready) begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      op_a_d      = op_a_sel;
      op_b_d      = op_b_sel;
      imm_d       = bus.id_imm;
      rs1_d       = bus.id_rs1;
      rs2_d       = bus.id_rs2;
      rd_d        = bus.id_rd;
      // An empty slot must never carry a register or memory write forward.
      reg_write_d = bus.id_valid & bus.id_reg_write;
      mem_read_d  = bus.id_valid & bus.id_mem_read;
      mem_write_d = bus.id_valid & bus.id_mem_write;
      alu_src_d   = bus.id_valid & bus.id_alu_src;
      alu_op_d    = bus.id_valid ? bus.id_alu_op : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_op_a      = op_a_q;
  assign bus.ex_op_b      = op_b_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_rs1       = rs1_q;
  assign bus.ex_rs2       = rs2_q;
  assign bus.ex_rd        = rd_q;
  assign bus.ex_reg_write = reg_write_q;
  assign bus.ex_mem_read  = mem_read_q;
  assign bus.ex_mem_write = mem_write_q;
  assign bus.ex_alu_src   = alu_src_q;
  assign bus.ex_alu_op    = alu_op_q;
  assign bus.bubble_count = bubble_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a cycle-level
// reference model; counters use a 4-bit width so saturation is reachable.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what EX should see after each edge.
  logic        m_valid, m_rw, m_mr, m_mw, m_as, m_known;
  logic [31:0] m_pc, m_opa, m_opb, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;
  int          m_bc, m_fc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf,
                                       input logic [31:0] exd, input logic [31:0] memd);
    if (s == 2'b01) return exd;
    if (s == 2'b10) return memd;
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_as = 0; m_op = 0;
    m_pc = 0; m_opa = 0; m_opb = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_known = 1;
    m_bc = 0; m_fc = 0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_as = 0; m_op = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_known = 0;
  endtask

  task automatic model_edge();
    if (bus.flush) begin
      model_bubble();
      m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    end else if (!bus.ex_ready) begin
      // hold
    end else if (bus.stall) begin
      model_bubble();
      m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
    end else begin
      m_valid = bus.id_valid;
      m_pc    = bus.id_pc;
      m_imm   = bus.id_imm;
      m_opa   = pick(bus.forward_a_src, bus.id_rs1_data, bus.ex_fwd_data, bus.mem_fwd_data);
      m_opb   = pick(bus.forward_b_src, bus.id_rs2_data, bus.ex_fwd_data, bus.mem_fwd_data);
      m_rs1   = bus.id_rs1;
      m_rs2   = bus.id_rs2;
      m_rd    = bus.id_rd;
      m_rw    = bus.id_valid && bus.id_reg_write;
      m_mr    = bus.id_valid && bus.id_mem_read;
      m_mw    = bus.id_valid && bus.id_mem_write;
      m_as    = bus.id_valid && bus.id_alu_src;
      m_op    = bus.id_valid ? bus.id_alu_op : 4'd0;
      m_known = 1;
    end
  endtask

  task automatic check_all();
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("ex_reg_write", bus.ex_reg_write, m_rw);
    chk("ex_mem_read", bus.ex_mem_read, m_mr);
    chk("ex_mem_write", bus.ex_mem_write, m_mw);
    chk("ex_alu_src", bus.ex_alu_src, m_as);
    chk("ex_alu_op", bus.ex_alu_op, m_op);
    chk("ex_rs1", bus.ex_rs1, m_rs1);
    chk("ex_rs2", bus.ex_rs2, m_rs2);
    chk("ex_rd", bus.ex_rd, m_rd);
    chk("bubble_count", bus.bubble_count, m_bc);
    chk("flush_count", bus.flush_count, m_fc);
    if (m_known) begin
      chk("ex_pc", bus.ex_pc, m_pc);
      chk("ex_op_a", bus.ex_op_a, m_opa);
      chk("ex_op_b", bus.ex_op_b, m_opb);
      chk("ex_imm", bus.ex_imm, m_imm);
    end
  endtask

  // Inputs are set just after a falling edge; this checks id_ready, clocks
  // one rising edge through the model and compares at the next falling edge.
  task automatic step();
    #1;
    chk("id_ready", bus.id_ready, bus.ex_ready && !bus.stall && !bus.flush);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_id();
    bus.id_valid     = 1'b1;
    bus.id_pc        = $urandom;
    bus.id_rs1       = 5'($urandom);
    bus.id_rs2       = 5'($urandom);
    bus.id_rd        = 5'($urandom_range(1, 31));
    bus.id_rs1_data  = $urandom;
    bus.id_rs2_data  = $urandom;
    bus.id_imm       = $urandom;
    bus.id_reg_write = 1'($urandom);
    bus.id_mem_read  = 1'($urandom);
    bus.id_mem_write = 1'($urandom);
    bus.id_alu_src   = 1'($urandom);
    bus.id_alu_op    = 4'($urandom);
    bus.ex_fwd_data  = $urandom;
    bus.mem_fwd_data = $urandom;
    bus.forward_a_src = 2'($urandom);
    bus.forward_b_src = 2'($urandom);
  endtask

  task automatic ctl(input logic st, input logic fl, input logic rdy);
    bus.stall    = st;
    bus.flush    = fl;
    bus.ex_ready = rdy;
  endtask

  initial begin
    logic [1:0]  srcs [3];
    logic [31:0] want [3];
    logic [31:0] saved_pc;
    int          bc0;
    n_chk = 0;
    n_err = 0;
    srcs[0] = 2'b01; srcs[1] = 2'b10; srcs[2] = 2'b11;
    want[0] = 32'h22; want[1] = 32'h33; want[2] = 32'h11;

    rst_n = 1'b0;
    rand_id();
    ctl(0, 0, 1);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Forwarding on op_a, then op_b.
    for (int i = 0; i < 3; i++) begin
      rand_id();
      bus.id_rs1_data = 32'h11; bus.id_rs2_data = 32'h11;
      bus.ex_fwd_data = 32'h22; bus.mem_fwd_data = 32'h33;
      bus.forward_a_src = srcs[i]; bus.forward_b_src = 2'b00;
      step();
      chk("fwd_a", bus.ex_op_a, want[i]);
    end
    for (int i = 0; i < 3; i++) begin
      rand_id();
      bus.id_rs1_data = 32'h11; bus.id_rs2_data = 32'h11;
      bus.ex_fwd_data = 32'h22; bus.mem_fwd_data = 32'h33;
      bus.forward_a_src = 2'b00; bus.forward_b_src = srcs[i];
      step();
      chk("fwd_b", bus.ex_op_b, want[i]);
    end

    // Load-use: one bubble, then the held instruction loads.
    rand_id();
    bus.id_pc = 32'h100; bus.id_rd = 5'd5; bus.id_reg_write = 1'b1;
    ctl(1, 0, 1);
    step();
    chk("lu_valid", bus.ex_valid, 1'b0);
    chk("lu_rw", bus.ex_reg_write, 1'b0);
    chk("lu_rd", bus.ex_rd, 5'd0);
    chk("lu_bubbles", bus.bubble_count, 4'd1);
    ctl(0, 0, 1);
    step();
    chk("lu_load_valid", bus.ex_valid, 1'b1);
    chk("lu_load_pc", bus.ex_pc, 32'h100);

    // Flush wins over stall and backpressure.
    bc0 = m_bc;
    rand_id();
    ctl(1, 1, 0);
    step();
    chk("fl_valid", bus.ex_valid, 1'b0);
    chk("fl_rw", bus.ex_reg_write, 1'b0);
    chk("fl_mw", bus.ex_mem_write, 1'b0);
    chk("fl_count", bus.flush_count, 4'd1);
    chk("fl_bubbles", bus.bubble_count, 4'(bc0));

    // Backpressure: three held cycles with changing ID inputs.
    rand_id();
    bus.id_valid = 1'b1;
    ctl(0, 0, 1);
    step();
    saved_pc = bus.ex_pc;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      ctl(1'($urandom), 0, 0);
      step();
      chk("bp_hold_pc", bus.ex_pc, saved_pc);
      chk("bp_hold_valid", bus.ex_valid, 1'b1);
    end
    rand_id();
    bus.id_pc = 32'hABC0;
    ctl(0, 0, 1);
    step();
    chk("bp_release_pc", bus.ex_pc, 32'hABC0);

    // Saturation of the bubble counter.
    for (int i = 0; i < 20; i++) begin
      rand_id();
      ctl(1, 0, 1);
      step();
    end
    chk("sat_bubbles", bus.bubble_count, 4'd15);
    ctl(1, 0, 1);
    step();
    chk("sat_bubbles_hold", bus.bubble_count, 4'd15);

    // Asynchronous reset while a live instruction is held.
    rand_id();
    ctl(0, 0, 1);
    step();
    ctl(0, 0, 0);
    step();
    chk("pre_rst_valid", bus.ex_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("rst_id_ready", bus.id_ready, 1'b0);
    ctl(0, 0, 1);
    #1;
    chk("rst_id_ready_follow", bus.id_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      bus.id_valid = ($urandom_range(0, 9) != 0);
      ctl($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage core, placed between decode and execute. It applies the stall and operand-forwarding decisions made by the hazard unit. On each accepted cycle it captures the decoded instruction, selecting each source operand from the register file, the EX result or the MEM result. It inserts a bubble on a load-use stall, kills its contents on a branch/jump flush, holds under execute backpressure, and counts bubbles and flushes for performance monitoring.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of each saturating performance counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid decoded instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  immediate
- id_reg_write, id_mem_read, id_mem_write, id_alu_src  in  1 each  control bits
- id_alu_op  in  4  ALU operation
- stall  in  1  load-use stall request from hazard unit
- flush  in  1  branch/jump redirect from EX
- forward_a_src, forward_b_src  in  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 regfile
- ex_fwd_data, mem_fwd_data  in  XLEN  forwarding data from the EX and MEM stages
- ex_ready  in  1  EX can accept a new instruction this cycle
- id_ready  out  1  ID may advance (freezes PC and IF/ID when low)
- ex_valid  out  1  register holds a live instruction
- ex_pc, ex_op_a, ex_op_b, ex_imm  out  XLEN each  registered fields
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered control
- ex_alu_op  out  4  registered ALU op
- bubble_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- Operand select, combinational on the ID side:
  - op_a = forward_a_src==01 ? ex_fwd_data : forward_a_src==10 ? mem_fwd_data : id_rs1_data.
  - op_b is selected the same way from forward_b_src.
- id_ready = ex_ready && !stall && !flush.
- Per-edge action, priority highest first:
  1. flush=1: ex_valid←0 and all control outputs ←0 (ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op). flush_count increments. Data fields are don't-care. Flush overrides ex_ready=0.
  2. ex_ready=0: all registered outputs hold.
  3. stall=1: bubble inserted. ex_valid←0, control outputs ←0, bubble_count increments.
  4. Otherwise, load. ex_valid←id_valid, and all fields are captured with op_a/op_b as selected.
- When id_valid=0 on a load, control outputs are forced to 0. No phantom register or memory write may leave this stage.
- Counters:
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - flush and stall in the same cycle: only flush_count increments.
  - A stall cycle held by ex_ready=0 does not increment bubble_count.
- rd/rs fields of a bubble are cleared to 0, so downstream hazard comparisons never match a bubble.

## Timing
- All ex_* outputs and counters are registered and update on the rising clk edge. Latency from ID inputs to ex_* is 1 cycle.
- id_ready is purely combinational from ex_ready, stall and flush.
- rst_n low asynchronously clears every registered output and both counters to 0. id_ready then follows its inputs.
- Reset release: the first edge with rst_n high performs a normal action.
- Reset asserted mid-hold discards the held instruction.
- Forwarding data is sampled on the same edge as the load. No extra cycle is allowed for a forwarded operand.
- One load-use stall yields exactly one bubble cycle if ex_ready=1 throughout.

## Test plan
- Reset: rst_n=0 mid-run with ex_valid=1 -> every output reads 0 immediately, before the next edge. Counters read 0.
- Forwarding: id_rs1_data=0x11, ex_fwd_data=0x22, mem_fwd_data=0x33.
  - forward_a_src=01 -> ex_op_a=0x22 next cycle.
  - forward_a_src=10 -> ex_op_a=0x33.
  - forward_a_src=11 -> ex_op_a=0x11.
  - Repeat all three for op_b.
- Load-use: stall=1 for one cycle with id_valid=1 -> id_ready=0 that cycle, then ex_valid=0, ex_reg_write=0, ex_rd=0, bubble_count=1. The next cycle loads the instruction.
- Flush: flush=1 together with stall=1 and ex_ready=0 -> ex_valid=0 and all control outputs 0. flush_count increments by 1; bubble_count is unchanged.
- Backpressure: ex_ready=0 for 3 cycles while ID inputs change -> ex_* outputs are unchanged for all 3 cycles and id_ready=0. The instruction presented on the first cycle with ex_ready=1 is then captured.
- Saturation: with CNT_W=4, apply 20 stall cycles -> bubble_count stops at 15 and stays at 15.
